// File: rtl/scanline_fetcher.sv
// rtl/scanline_fetcher.sv - ping-pong line buffer fetcher and pixel player for line-doubled rows
module scanline_fetcher #(
  parameter int PIXEL_W     = 8,
  parameter int WORD_W      = 16,
  parameter int LINE_PIXELS = 320,
  parameter int LINE_ROWS   = 240,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk40,
  input  logic              resetN,
  input  logic              lineStarting,
  input  logic              videoActive,
  input  logic [9:0]        hPos,
  input  logic              nextFrameActive,
  input  logic [9:0]        nextVPos,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [WORD_W-1:0] memData,
  output logic [PIXEL_W-1:0] pixelOut,
  output logic              pixelValid,
  output logic              underrun
);

  localparam int PPW       = WORD_W / PIXEL_W;
  localparam int WPL       = LINE_PIXELS / PPW;
  localparam int IDX_W     = $clog2(WPL);
  localparam int PIX_IDX_W = $clog2(LINE_PIXELS);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_next;

  logic [PIXEL_W-1:0] line_buf [2][LINE_PIXELS];
  logic [1:0]         buf_valid;
  logic [8:0]         buf_tag [2];
  logic               front_sel;
  logic               fetch_buf;
  logic [IDX_W-1:0]   word_idx;
  logic               blank;

  logic               active_line;
  logic               front_hit;
  logic               back_hit;
  logic               new_front;
  logic               target;
  logic [10:0]        next_row;
  logic               next_held;
  logic               zero_held;
  logic               start_fetch;
  logic [8:0]         start_row;
  logic [ADDR_W-1:0]  start_addr;
  logic               last_word;
  logic [PIXEL_W-1:0] rd_pix;

  // Tag lookups run against the tags as they stand before any swap; a swap never changes tags.
  always_comb begin
    active_line = lineStarting && nextFrameActive;
    front_hit   = buf_valid[front_sel] && ({1'b0, buf_tag[front_sel]} == nextVPos);
    back_hit    = buf_valid[~front_sel] && ({1'b0, buf_tag[~front_sel]} == nextVPos);
    new_front   = (active_line && !front_hit && back_hit) ? ~front_sel : front_sel;
    target      = ~new_front;
    next_row    = {1'b0, nextVPos} + 11'd1;
    next_held   = (buf_valid[0] && ({2'b0, buf_tag[0]} == next_row)) ||
                  (buf_valid[1] && ({2'b0, buf_tag[1]} == next_row));
    zero_held   = (buf_valid[0] && (buf_tag[0] == 9'd0)) ||
                  (buf_valid[1] && (buf_tag[1] == 9'd0));
    last_word   = (word_idx == IDX_W'(WPL - 1));
    rd_pix      = line_buf[front_sel][hPos[PIX_IDX_W-1:0]];
  end

  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    start_row   = '0;
    case (state)
      IDLE: begin
        if (lineStarting) begin
          if (nextFrameActive) begin
            if ((next_row < 11'(LINE_ROWS)) && !next_held) begin
              start_fetch = 1'b1;
              start_row   = next_row[8:0];
            end
          end else if (!zero_held) begin
            start_fetch = 1'b1;
          end
        end
        if (start_fetch) state_next = FETCH;
      end
      FETCH: begin
        if (memAck && last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    start_addr = ADDR_W'(BASE_ADDR + WPL * int'(start_row));
    memReq     = (state == FETCH);
  end

  always_ff @(posedge clk40) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk40) begin
    if (!resetN) begin
      buf_valid  <= '0;
      buf_tag[0] <= '0;
      buf_tag[1] <= '0;
      front_sel  <= 1'b0;
      fetch_buf  <= 1'b0;
      word_idx   <= '0;
      memAddr    <= '0;
      blank      <= 1'b0;
      underrun   <= 1'b0;
      pixelOut   <= '0;
      pixelValid <= 1'b0;
    end else begin
      front_sel <= new_front;
      if (active_line) begin
        blank <= !(front_hit || back_hit);
        if (!(front_hit || back_hit)) underrun <= 1'b1;
      end
      if (start_fetch) begin
        buf_valid[target] <= 1'b0;
        buf_tag[target]   <= start_row;
        fetch_buf         <= target;
        word_idx          <= '0;
        memAddr           <= start_addr;
      end else if ((state == FETCH) && memAck) begin
        word_idx <= word_idx + IDX_W'(1);
        memAddr  <= memAddr + ADDR_W'(1);
        if (last_word) buf_valid[fetch_buf] <= 1'b1;
      end
      pixelValid <= videoActive;
      pixelOut   <= (videoActive && !blank && (hPos < 10'(LINE_PIXELS))) ? rd_pix : '0;
    end
  end

  // The fetch target is never the front buffer, so these writes cannot disturb playout.
  always_ff @(posedge clk40) begin
    if (resetN && (state == FETCH) && memAck) begin
      for (int p = 0; p < PPW; p++) begin
        line_buf[fetch_buf][PIX_IDX_W'(word_idx) * PIX_IDX_W'(PPW) + PIX_IDX_W'(p)] <=
          memData[p*PIXEL_W +: PIXEL_W];
      end
    end
  end

endmodule

// File: tb/tb_scanline_fetcher.sv
// tb/tb_scanline_fetcher.sv - directed bench for scanline_fetcher
module tb_scanline_fetcher;

  logic        clk40 = 1'b0;
  logic        resetN;
  logic        line_starting, video_active, next_frame_active;
  logic [9:0]  h_pos, next_vpos;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_data;
  logic [7:0]  pixel_out;
  logic        pixel_valid, underrun;

  logic        ls2, ack2;
  logic [9:0]  nvp2;
  logic        mem_req2, pv2, ur2;
  logic [15:0] mem_addr2;
  logic [7:0]  pix2;

  int n_vec  = 0;
  int n_miss = 0;
  int ack_cnt = 0;
  int first_addr = -1;
  logic mon_en = 1'b0;

  always #5 clk40 = ~clk40;

  scanline_fetcher dut (
    .clk40(clk40), .resetN(resetN), .lineStarting(line_starting), .videoActive(video_active),
    .hPos(h_pos), .nextFrameActive(next_frame_active), .nextVPos(next_vpos),
    .memReq(mem_req), .memAddr(mem_addr), .memAck(mem_ack), .memData(mem_data),
    .pixelOut(pixel_out), .pixelValid(pixel_valid), .underrun(underrun)
  );

  scanline_fetcher #(.BASE_ADDR(1000)) dut_base (
    .clk40(clk40), .resetN(resetN), .lineStarting(ls2), .videoActive(1'b0),
    .hPos(10'd0), .nextFrameActive(1'b1), .nextVPos(nvp2),
    .memReq(mem_req2), .memAddr(mem_addr2), .memAck(ack2), .memData(16'h0000),
    .pixelOut(pix2), .pixelValid(pv2), .underrun(ur2)
  );

  // Memory image: row r, column c holds (c + 7*r) mod 256.
  always_comb begin
    int row, w;
    row = int'(mem_addr) / 160;
    w   = int'(mem_addr) % 160;
    mem_data = {8'(2*w + 1 + 7*row), 8'(2*w + 7*row)};
  end

  always @(posedge clk40) begin
    if (mon_en && mem_req && mem_ack) begin
      if (ack_cnt == 0) first_addr = int'(mem_addr);
      ack_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic run_line(input logic [9:0] vpos, input int row);
    line_starting = 1'b1; next_frame_active = 1'b1; next_vpos = vpos;
    tick();
    line_starting = 1'b0;
    for (int c = 0; c < 320; c++) begin
      h_pos = 10'(c); video_active = 1'b1;
      tick();
      check("pixel", 32'(pixel_out), (row < 0) ? 32'd0 : 32'((c + 7*row) % 256));
      if (c == 0 || c == 319) check("pixel_valid", 32'(pixel_valid), 32'd1);
    end
    video_active = 1'b0; h_pos = 10'd0;
    tick();
    check("pixel_valid_blank", 32'(pixel_valid), 32'd0);
    check("pixel_blank", 32'(pixel_out), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    resetN = 1'b0; line_starting = 1'b0; video_active = 1'b0; next_frame_active = 1'b0;
    h_pos = '0; next_vpos = '0; mem_ack = 1'b0;
    ls2 = 1'b0; ack2 = 1'b1; nvp2 = '0;
    repeat (3) tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_pix", 32'(pixel_out), 32'd0);
    check("rst_pv", 32'(pixel_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    resetN = 1'b1;
    tick();

    // Miss on row 5 sets underrun and starts a stalled fetch of row 6; reset then abandons it.
    line_starting = 1'b1; next_frame_active = 1'b1; next_vpos = 10'd5;
    tick();
    line_starting = 1'b0;
    check("miss_underrun", 32'(underrun), 32'd1);
    check("row6_req", 32'(mem_req), 32'd1);
    check("row6_addr", 32'(mem_addr), 32'd960);
    tick();
    resetN = 1'b0;
    tick();
    check("midfetch_rst_req", 32'(mem_req), 32'd0);
    check("midfetch_rst_underrun", 32'(underrun), 32'd0);
    check("midfetch_rst_pix", 32'(pixel_out), 32'd0);
    check("midfetch_rst_addr", 32'(mem_addr), 32'd0);
    repeat (2) tick();
    resetN = 1'b1;
    tick();

    // Vblank fetch of row 0 with ack tied high.
    mem_ack = 1'b1;
    line_starting = 1'b1; next_frame_active = 1'b0; next_vpos = 10'd0;
    tick();
    line_starting = 1'b0;
    for (int i = 0; i < 160; i++) begin
      check("vb_req", 32'(mem_req), 32'd1);
      check("vb_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    check("vb_req_done", 32'(mem_req), 32'd0);
    repeat (3) tick();

    // Scan lines 0 and 1 both show row 0; only row 1 is fetched across them.
    mon_en = 1'b1;
    run_line(10'd0, 0);
    run_line(10'd0, 0);
    mon_en = 1'b0;
    check("row1_ack_count", 32'(ack_cnt), 32'd160);
    check("row1_first_addr", 32'(first_addr), 32'd160);
    check("no_underrun", 32'(underrun), 32'd0);

    // Row 1 shown while row 2 fetch stalls; row 2 then misses and the line blanks.
    mem_ack = 1'b0;
    run_line(10'd1, 1);
    check("row2_req", 32'(mem_req), 32'd1);
    check("row2_addr", 32'(mem_addr), 32'd320);
    run_line(10'd2, -1);
    check("late_underrun", 32'(underrun), 32'd1);
    mem_ack = 1'b1;
    repeat (161) tick();
    check("row2_done_req", 32'(mem_req), 32'd0);
    check("underrun_sticky", 32'(underrun), 32'd1);
    run_line(10'd2, 2);
    mem_ack = 1'b0;

    // BASE_ADDR=1000 instance fetching row 239.
    ls2 = 1'b1; nvp2 = 10'd238;
    tick();
    ls2 = 1'b0;
    check("base_first_req", 32'(mem_req2), 32'd1);
    check("base_first_addr", 32'(mem_addr2), 32'd39240);
    repeat (159) tick();
    check("base_last_req", 32'(mem_req2), 32'd1);
    check("base_last_addr", 32'(mem_addr2), 32'd39399);
    tick();
    check("base_done_req", 32'(mem_req2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
